// File: rtl/golden_nonce_queue.sv
// Golden-nonce FIFO between the hash match detect and the serial transmitter.
// Hits that arrive while the transmitter is busy are queued; a guard window covers busy-rise lag.
module golden_nonce_queue #(
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned ADDR_W        = 3,
   parameter int unsigned GUARD         = 2,
   parameter bit          FLUSH_ON_LOAD = 1'b1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              hit_valid_i,
   input  logic [31:0]       hit_nonce_i,
   input  logic              work_load_i,
   input  logic              tx_busy_i,
   output logic              tx_send_o,
   output logic [31:0]       tx_word_o,
   output logic [ADDR_W:0]   count_o,
   output logic              overflow_o,
   output logic [7:0]        dropped_cnt_o
);

   typedef enum logic [1:0] {StIdle, StGuardWait, StDrain} state_e;

   localparam logic [ADDR_W:0] CntFull   = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      GuardInit = 4'(GUARD);

   state_e              state_q, state_d;
   logic [3:0]          guard_q, guard_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                tx_send_q, tx_send_d;
   logic [31:0]         tx_word_q, tx_word_d;
   logic                overflow_q, overflow_d;
   logic [7:0]          dropped_q, dropped_d;
   logic [31:0]         mem_q [DEPTH];

   logic pop;
   logic push;
   logic drop;
   logic flush;

   // State register, including all queue bookkeeping.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         guard_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         tx_send_q  <= 1'b0;
         tx_word_q  <= '0;
         overflow_q <= 1'b0;
         dropped_q  <= '0;
      end else begin
         state_q    <= state_d;
         guard_q    <= guard_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         tx_send_q  <= tx_send_d;
         tx_word_q  <= tx_word_d;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
      end
   end

   // Storage needs no reset: entries are only read behind a nonzero count.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= hit_nonce_i;
      end
   end

   // Next-state logic for the send FSM.
   always_comb begin
      state_d = state_q;
      guard_d = guard_q;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               state_d = StGuardWait;
               guard_d = GuardInit;
            end
         end
         StGuardWait: begin
            if (guard_q <= 4'd1) begin
               state_d = StDrain;
            end else begin
               guard_d = guard_q - 4'd1;
            end
         end
         StDrain: begin
            if (!tx_busy_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic: send strobe and captured head word.
   always_comb begin
      pop       = (state_q == StIdle) && (count_q != '0) && !tx_busy_i;
      tx_send_d = pop;
      tx_word_d = pop ? mem_q[rd_ptr_q] : tx_word_q;
   end

   // Queue pointers, occupancy and drop accounting.
   always_comb begin
      flush = FLUSH_ON_LOAD && work_load_i;
      // A pop frees a slot in the same cycle, so a full queue still accepts.
      push  = hit_valid_i && !flush && ((count_q != CntFull) || pop);
      drop  = hit_valid_i && !flush && (count_q == CntFull) && !pop;

      wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;

      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else if (pop) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      if (flush) begin
         count_d = '0;
      end else if (push && !pop) begin
         count_d = count_q + (ADDR_W + 1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (ADDR_W + 1)'(1);
      end else begin
         count_d = count_q;
      end

      overflow_d = overflow_q | drop;
      dropped_d  = (drop && (dropped_q != 8'hff)) ? dropped_q + 8'd1 : dropped_q;
   end

   assign tx_send_o     = tx_send_q;
   assign tx_word_o     = tx_word_q;
   assign count_o       = count_q;
   assign overflow_o    = overflow_q;
   assign dropped_cnt_o = dropped_q;

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Randomised bench for golden_nonce_queue: lane 0 flushes on load, lane 1 keeps entries.
// A queue-based model predicts every output each cycle; a mock transmitter drives busy.
module tb_golden_nonce_queue;

   localparam int DEPTH = 8;
   localparam int GUARD = 2;

   logic        clk;
   logic        reset;
   logic        hit_valid;
   logic [31:0] hit_nonce;
   logic        work_load;
   logic        force_busy;
   logic        mock_busy;
   logic        tx_busy;

   logic        tx_send_w   [2];
   logic [31:0] tx_word_w   [2];
   logic [3:0]  count_w     [2];
   logic        overflow_w  [2];
   logic [7:0]  dropped_w   [2];

   int vectors     = 0;
   int miscompares = 0;

   assign tx_busy = force_busy | mock_busy;

   golden_nonce_queue #(
      .DEPTH(DEPTH), .ADDR_W(3), .GUARD(GUARD), .FLUSH_ON_LOAD(1'b1)
   ) u_dut0 (
      .clk_i(clk), .reset_i(reset), .hit_valid_i(hit_valid), .hit_nonce_i(hit_nonce),
      .work_load_i(work_load), .tx_busy_i(tx_busy), .tx_send_o(tx_send_w[0]),
      .tx_word_o(tx_word_w[0]), .count_o(count_w[0]), .overflow_o(overflow_w[0]),
      .dropped_cnt_o(dropped_w[0])
   );

   golden_nonce_queue #(
      .DEPTH(DEPTH), .ADDR_W(3), .GUARD(GUARD), .FLUSH_ON_LOAD(1'b0)
   ) u_dut1 (
      .clk_i(clk), .reset_i(reset), .hit_valid_i(hit_valid), .hit_nonce_i(hit_nonce),
      .work_load_i(work_load), .tx_busy_i(tx_busy), .tx_send_o(tx_send_w[1]),
      .tx_word_o(tx_word_w[1]), .count_o(count_w[1]), .overflow_o(overflow_w[1]),
      .dropped_cnt_o(dropped_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int lane, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s lane%0d: got %h expected %h at %0t", name, lane, act, exp, $time);
      end
   endtask

   // Behavioural model: a plain queue per lane plus a "cycles until ready" view of the sender.
   logic [31:0] mq [2][$];
   bit          m_idle  [2];
   int          m_guard [2];
   bit          e_send  [2];
   logic [31:0] e_word  [2];
   bit          e_ovf   [2];
   int          e_drop  [2];
   bit          started = 1'b0;

   always @(posedge clk) begin
      started <= 1'b1;
      for (int l = 0; l < 2; l++) begin
         if (reset) begin
            mq[l].delete();
            m_idle[l]  = 1'b1;
            m_guard[l] = 0;
            e_send[l]  = 1'b0;
            e_word[l]  = '0;
            e_ovf[l]   = 1'b0;
            e_drop[l]  = 0;
         end else begin
            e_send[l] = 1'b0;
            if (m_idle[l]) begin
               if (mq[l].size() > 0 && !tx_busy) begin
                  e_word[l]  = mq[l].pop_front();
                  e_send[l]  = 1'b1;
                  m_idle[l]  = 1'b0;
                  m_guard[l] = GUARD;
               end
            end else if (m_guard[l] > 0) begin
               m_guard[l]--;
            end else if (!tx_busy) begin
               m_idle[l] = 1'b1;
            end
            if (l == 0 && work_load) begin
               mq[l].delete();
            end else if (hit_valid) begin
               if (mq[l].size() < DEPTH) begin
                  mq[l].push_back(hit_nonce);
               end else begin
                  e_ovf[l] = 1'b1;
                  if (e_drop[l] < 255) e_drop[l]++;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int l = 0; l < 2; l++) begin
            chk("tx_send", l, 32'(tx_send_w[l]), 32'(e_send[l]));
            chk("tx_word", l, tx_word_w[l], e_word[l]);
            chk("count", l, 32'(count_w[l]), 32'(mq[l].size()));
            chk("overflow", l, 32'(overflow_w[l]), 32'(e_ovf[l]));
            chk("dropped_cnt", l, 32'(dropped_w[l]), 32'(e_drop[l]));
         end
      end
   end

   // Mock serial transmitter on lane 0: busy rises 2 cycles after a send, lasts frame_len.
   int rise_cd   = 0;
   int frame_cd  = 0;
   int frame_len = 6;
   always @(negedge clk) begin
      if (reset) begin
         rise_cd   = 0;
         frame_cd  = 0;
         mock_busy = 1'b0;
      end else begin
         if (frame_cd > 0) frame_cd--;
         if (rise_cd > 0) begin
            rise_cd--;
            if (rise_cd == 0) frame_cd = frame_len;
         end
         if (tx_send_w[0]) rise_cd = 2;
         mock_busy = (frame_cd > 0);
      end
   end

   task automatic hit(input logic [31:0] n);
      hit_valid = 1'b1;
      hit_nonce = n;
      @(negedge clk);
      hit_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [7:0] drop_snap;

   initial begin
      reset      = 1'b1;
      hit_valid  = 1'b0;
      hit_nonce  = '0;
      work_load  = 1'b0;
      force_busy = 1'b0;
      mock_busy  = 1'b0;
      idle(3);
      chk("reset count", 0, 32'(count_w[0]), 32'd0);
      chk("reset tx_word", 0, tx_word_w[0], 32'd0);
      reset = 1'b0;
      idle(5);

      // Single hit with an idle transmitter: count 1, then the send.
      hit(32'h1afda099);
      chk("t1 count after push", 0, 32'(count_w[0]), 32'd1);
      chk("t1 no early send", 0, 32'(tx_send_w[0]), 32'd0);
      idle(1);
      chk("t1 send", 0, 32'(tx_send_w[0]), 32'd1);
      chk("t1 word", 0, tx_word_w[0], 32'h1afda099);
      chk("t1 count after pop", 0, 32'(count_w[0]), 32'd0);
      idle(1);
      chk("t1 one-cycle strobe", 0, 32'(tx_send_w[0]), 32'd0);
      idle(40);

      // Burst while busy, then drain.
      force_busy = 1'b1;
      for (int i = 1; i <= 3; i++) hit(32'ha0000000 + 32'(i));
      chk("t2 count", 0, 32'(count_w[0]), 32'd3);
      force_busy = 1'b0;
      idle(100);

      // Overflow: ten hits into an eight-entry queue.
      force_busy = 1'b1;
      for (int i = 0; i < 10; i++) hit(32'(i));
      chk("t3 count", 0, 32'(count_w[0]), 32'd8);
      chk("t3 overflow", 0, 32'(overflow_w[0]), 32'd1);
      chk("t3 dropped", 0, 32'(dropped_w[0]), 32'd2);
      force_busy = 1'b0;
      idle(200);

      // Full queue with a pop and push in the same cycle.
      force_busy = 1'b1;
      for (int i = 0; i < 8; i++) hit(32'h0000b000 + 32'(i));
      drop_snap  = dropped_w[0];
      force_busy = 1'b0;
      hit(32'h0000beef);
      chk("t4 send", 0, 32'(tx_send_w[0]), 32'd1);
      chk("t4 count", 0, 32'(count_w[0]), 32'd8);
      chk("t4 dropped", 0, 32'(dropped_w[0]), 32'(drop_snap));
      idle(250);

      // Flush with one send in flight and a simultaneous hit.
      force_busy = 1'b1;
      for (int i = 1; i <= 4; i++) hit(32'h11111111 * 32'(i));
      force_busy = 1'b0;
      idle(1);
      drop_snap = dropped_w[0];
      work_load = 1'b1;
      hit(32'h12345678);
      work_load = 1'b0;
      chk("t5 flushed count", 0, 32'(count_w[0]), 32'd0);
      chk("t5 kept count", 1, 32'(count_w[1]), 32'd4);
      chk("t5 dropped", 0, 32'(dropped_w[0]), 32'(drop_snap));
      idle(200);

      // Reset while draining with entries queued.
      force_busy = 1'b1;
      for (int i = 0; i < 6; i++) hit(32'h60000000 + 32'(i));
      force_busy = 1'b0;
      idle(1);
      force_busy = 1'b1;
      for (int i = 0; i < 5; i++) hit(32'h70000000 + 32'(i));
      idle(3);
      reset = 1'b1;
      idle(1);
      chk("t6 count", 0, 32'(count_w[0]), 32'd0);
      chk("t6 dropped", 0, 32'(dropped_w[0]), 32'd0);
      chk("t6 overflow", 0, 32'(overflow_w[0]), 32'd0);
      chk("t6 tx_send", 0, 32'(tx_send_w[0]), 32'd0);
      idle(1);
      reset      = 1'b0;
      force_busy = 1'b0;
      idle(2);
      hit(32'hcafef00d);
      chk("t6 no early send", 0, 32'(tx_send_w[0]), 32'd0);
      idle(1);
      chk("t6 send", 0, 32'(tx_send_w[0]), 32'd1);
      chk("t6 word", 0, tx_word_w[0], 32'hcafef00d);
      idle(40);

      // Random traffic.
      for (int c = 0; c < 4000; c++) begin
         hit_valid = ($urandom_range(0, 2) == 0);
         hit_nonce = $urandom;
         work_load = ($urandom_range(0, 49) == 0);
         reset     = ($urandom_range(0, 799) == 0);
         if ($urandom_range(0, 24) == 0) force_busy = ~force_busy;
         if ($urandom_range(0, 31) == 0) frame_len = $urandom_range(2, 12);
         @(negedge clk);
      end
      hit_valid  = 1'b0;
      work_load  = 1'b0;
      reset      = 1'b0;
      force_busy = 1'b0;
      idle(300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
